// File: rtl/bc_poly_ctrl.sv
// Control block sequencing Horner evaluation on the iterative polynomial datapath:
// S = a[DEGREE], then DEGREE rounds of H = S*X, S = H + a[i].
module bc_poly_ctrl #(
  parameter int unsigned DEGREE    = 3,
  parameter int unsigned DONE_HOLD = 1,
  parameter int unsigned CW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ack,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          lx,
  output logic          lh,
  output logic          ls,
  output logic          m_s,
  output logic [CW-1:0] coef_sel
);

  if (DEGREE < 1 || DEGREE > 15) begin : g_bad_degree
    $error("bc_poly_ctrl: DEGREE must lie in 1..15");
  end
  if ((2 ** CW) <= DEGREE) begin : g_bad_cw
    $error("bc_poly_ctrl: CW too narrow to index coefficient DEGREE");
  end

  localparam logic [CW-1:0] IdxInit = CW'(DEGREE - 1);
  localparam logic [CW-1:0] CoefTop = CW'(DEGREE);
  localparam logic          HoldDone = (DONE_HOLD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul,
    StAdd,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // abort outranks every other input; in IDLE it also swallows a simultaneous start
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          idx_d   = IdxInit;
        end
      end
      StLoad: state_d = abort ? StIdle : StMul;
      StMul:  state_d = abort ? StIdle : StAdd;
      StAdd: begin
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q != '0) begin
          state_d = StMul;
          idx_d   = idx_q - 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (abort || ack || !HoldDone) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    lx       = 1'b0;
    lh       = 1'b0;
    ls       = 1'b0;
    m_s      = 1'b0;
    coef_sel = '0;
    unique case (state_q)
      StIdle: ready = 1'b1;
      StLoad: begin
        busy     = 1'b1;
        lx       = 1'b1;
        ls       = 1'b1;
        coef_sel = CoefTop;
      end
      StMul: begin
        busy     = 1'b1;
        lh       = 1'b1;
        coef_sel = idx_q;
      end
      StAdd: begin
        busy     = 1'b1;
        ls       = 1'b1;
        m_s      = 1'b1;
        coef_sel = idx_q;
      end
      StDone: done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  a_status_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot({ready, busy, done}));

  a_last_add_done : assert property (@(posedge clk) disable iff (!rst)
    (state_q == StAdd && idx_q == '0 && !abort) |=> done);

endmodule

// File: tb/tb_bc_poly_ctrl.sv
// Scoreboard bench for bc_poly_ctrl: four instances with different DEGREE/DONE_HOLD,
// directed per-cycle vectors with hand-written expected output words.
module tb_bc_poly_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] st = '0;
  logic [3:0] ab = '0;
  logic [3:0] akv = '0;
  logic [10:0] obs [4];

  always #5 clk = ~clk;

  // instance 0: D3/H1, 1: D1/H0, 2: D2/H0, 3: D15/H1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic r, b, d, x, h, s, m;
    logic [3:0] c;
    bc_poly_ctrl #(
      .DEGREE   ((g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 15),
      .DONE_HOLD((g == 1 || g == 2) ? 0 : 1),
      .CW       (4)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (st[g]),
      .abort   (ab[g]),
      .ack     (akv[g]),
      .ready   (r),
      .busy    (b),
      .done    (d),
      .lx      (x),
      .lh      (h),
      .ls      (s),
      .m_s     (m),
      .coef_sel(c)
    );
    assign obs[g] = {r, b, d, x, h, s, m, c};
  end

  // {ready, busy, done, lx, lh, ls, m_s, coef_sel[3:0]}
  function automatic logic [10:0] o_idle();
    return {7'b100_0000, 4'h0};
  endfunction
  function automatic logic [10:0] o_load(input logic [3:0] c);
    return {7'b010_1010, c};
  endfunction
  function automatic logic [10:0] o_mul(input logic [3:0] c);
    return {7'b010_0100, c};
  endfunction
  function automatic logic [10:0] o_add(input logic [3:0] c);
    return {7'b010_0011, c};
  endfunction
  function automatic logic [10:0] o_done();
    return {7'b001_0000, 4'h0};
  endfunction

  typedef struct {
    int          k;
    logic [10:0] e;
    string       nm;
  } exp_t;

  exp_t sb[$];
  event imm_ev;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   finished = 1'b0;

  // monitor: drains the scoreboard after each falling edge, or on demand mid-cycle
  initial begin
    forever begin
      @(negedge clk or imm_ev);
      while (sb.size() > 0) begin
        exp_t it;
        it = sb.pop_front();
        n_vec++;
        if (obs[it.k] !== it.e) begin
          n_miss++;
          $display("FAIL %s inst%0d: got %h want %h", it.nm, it.k, obs[it.k], it.e);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!finished) begin
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $fatal(1);
    end
  end

  // apply inputs to instance k for one edge; e is the output word after that edge
  task automatic step(input int k, input logic s, input logic a, input logic ak,
                      input logic [10:0] e, input string nm);
    st[k]  = s;
    ab[k]  = a;
    akv[k] = ak;
    @(posedge clk);
    sb.push_back('{k, e, nm});
    #1;
    st[k]  = 1'b0;
    ab[k]  = 1'b0;
    akv[k] = 1'b0;
  endtask

  task automatic expect_now(input int k, input logic [10:0] e, input string nm);
    sb.push_back('{k, e, nm});
    -> imm_ev;
    #0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) expect_now(k, o_idle(), "reset_state");
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (obs[k] !== o_idle()) begin
        n_miss++;
        $display("FAIL reset_direct inst%0d: got %h want %h", k, obs[k], o_idle());
      end
    end
    rst = 1'b1;

    // 1: D3, done held until ack
    step(0, 1, 0, 0, o_load(4'd3), "t1_load");
    for (int i = 2; i >= 0; i--) begin
      step(0, 0, 0, 0, o_mul(4'(i)), "t1_mul");
      step(0, 0, 0, 0, o_add(4'(i)), "t1_add");
    end
    step(0, 0, 0, 0, o_done(), "t1_done");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, o_done(), "t1_hold");
    step(0, 0, 0, 1, o_idle(), "t1_ack");

    // 2: D1, single-cycle done pulse
    step(1, 1, 0, 0, o_load(4'd1), "t2_load");
    step(1, 0, 0, 0, o_mul(4'd0), "t2_mul");
    step(1, 0, 0, 0, o_add(4'd0), "t2_add");
    step(1, 0, 0, 0, o_done(), "t2_done");
    step(1, 0, 0, 0, o_idle(), "t2_idle");

    // 3: abort in second MUL, then restart reloads idx; abort in LOAD
    step(0, 1, 0, 0, o_load(4'd3), "t3_load");
    step(0, 0, 0, 0, o_mul(4'd2), "t3_mul");
    step(0, 0, 0, 0, o_add(4'd2), "t3_add");
    step(0, 0, 0, 0, o_mul(4'd1), "t3_mul2");
    step(0, 0, 1, 0, o_idle(), "t3_abort");
    step(0, 0, 0, 0, o_idle(), "t3_no_done");
    step(0, 1, 0, 0, o_load(4'd3), "t3_restart");
    step(0, 0, 1, 0, o_idle(), "t3_abort_load");

    // 4: asynchronous reset mid-cycle during ADD
    step(0, 1, 0, 0, o_load(4'd3), "t4_load");
    step(0, 0, 0, 0, o_mul(4'd2), "t4_mul");
    step(0, 0, 0, 0, o_add(4'd2), "t4_add");
    @(negedge clk);
    #1 rst = 1'b0;
    #1 expect_now(0, o_idle(), "t4_async_rst");
    st[0] = 1'b1;
    @(posedge clk);
    #1 expect_now(0, o_idle(), "t4_rst_hold1");
    @(posedge clk);
    #1 expect_now(0, o_idle(), "t4_rst_hold2");
    rst   = 1'b1;
    st[0] = 1'b0;
    step(0, 1, 0, 0, o_load(4'd3), "t4_after_rst");
    step(0, 0, 1, 0, o_idle(), "t4_abort");

    // 5a: start held through a run is ignored; start+ack in DONE goes to IDLE only
    step(0, 1, 0, 0, o_load(4'd3), "t5_load");
    for (int i = 2; i >= 0; i--) begin
      step(0, 1, 0, 0, o_mul(4'(i)), "t5_busy_mul");
      step(0, 1, 0, 0, o_add(4'(i)), "t5_busy_add");
    end
    step(0, 1, 0, 0, o_done(), "t5_done");
    step(0, 1, 0, 0, o_done(), "t5_done_start");
    step(0, 1, 0, 1, o_idle(), "t5_start_ack");
    step(0, 0, 0, 0, o_idle(), "t5_not_queued");
    // 5b: start+abort in IDLE
    step(0, 1, 1, 0, o_idle(), "t5_start_abort");
    step(0, 0, 0, 0, o_idle(), "t5_idle");
    // 5c: start held high, D2 pulse mode: period LOAD,MUL,ADD,MUL,ADD,DONE,IDLE
    for (int r = 0; r < 2; r++) begin
      step(2, 1, 0, 0, o_load(4'd2), "t5_bb_load");
      for (int i = 1; i >= 0; i--) begin
        step(2, 1, 0, 0, o_mul(4'(i)), "t5_bb_mul");
        step(2, 1, 0, 0, o_add(4'(i)), "t5_bb_add");
      end
      step(2, 1, 0, 0, o_done(), "t5_bb_done");
      step(2, 1, 0, 0, o_idle(), "t5_bb_idle");
    end
    step(2, 0, 0, 0, o_idle(), "t5_bb_stop");

    // 6: D15, full descent; abort in DONE acts as ack
    step(3, 1, 0, 0, o_load(4'd15), "t6_load");
    for (int i = 14; i >= 0; i--) begin
      step(3, 0, 0, 0, o_mul(4'(i)), "t6_mul");
      step(3, 0, 0, 0, o_add(4'(i)), "t6_add");
    end
    step(3, 0, 0, 0, o_done(), "t6_done");
    step(3, 0, 0, 0, o_done(), "t6_hold");
    step(3, 0, 1, 0, o_idle(), "t6_abort_done");

    @(negedge clk);
    #1;
    finished = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss != 0) begin
      $display("FAIL");
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
